// File: rtl/bp_fe_fetch_buffer.sv
// bp_fe_fetch_buffer
//
// Fetch decoupling buffer between the FE PC generator and the FE
// memory/icache stage. Fetch requests are issued against a credit pool of
// depth_p; every issued request owns either a response slot in the buffer
// or a pending drop after a redirect. In-order multi-instruction responses
// land in a circular buffer and drain to the FE queue one instruction per
// cycle. A flush empties the buffer and converts every in-flight request
// into a pending drop, so the FE can re-steer without waiting for the
// memory pipe to empty.
//
// Handshakes: a transfer happens on a rising clk_i edge where valid and
// ready are both high. Valid never depends on ready.
//   issue = req_v_i & req_ready_o
//   pop   = out_v_o & out_ready_i
// resp_v_i has no ready. Credits guarantee that a response always has
// somewhere to go.
//
// Ports:
//   clk_i, reset_n_i   clock, asynchronous active-low reset
//   req_v_i            PC gen wants to issue a fetch
//   req_ready_o        a credit is free (always low in a flush cycle)
//   resp_v_i           in-order fetch response valid
//   resp_pc_i          PC of slot 0 of the response
//   resp_instr_i       slot i at bits [i*instr_width_p +: instr_width_p]
//   resp_cnt_i         number of valid slots, 1..fetch_width_p
//   resp_fault_i       fetch fault; the entry yields one instruction of zeros
//   flush_i            redirect: discard buffered and in-flight responses
//   out_v_o            instruction valid to the FE queue
//   out_pc_o           instruction PC
//   out_instr_o        instruction bits
//   out_fault_o        fault marker
//   out_ready_i        FE queue ready
//   occupancy_o        buffered entries
//   outstanding_o      issued, unreturned, non-discarded requests
module bp_fe_fetch_buffer #(
  parameter int vaddr_width_p = 39,
  parameter int instr_width_p = 32,
  parameter int fetch_width_p = 2,
  parameter int depth_p       = 4,
  parameter int lg_depth_lp   = ((depth_p + 1) <= 2) ? 1 : $clog2(depth_p + 1),
  parameter int lg_fetch_lp   = ((fetch_width_p + 1) <= 2) ? 1 : $clog2(fetch_width_p + 1)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic                                   req_v_i,
  output logic                                   req_ready_o,
  input  logic                                   resp_v_i,
  input  logic [vaddr_width_p-1:0]               resp_pc_i,
  input  logic [fetch_width_p*instr_width_p-1:0] resp_instr_i,
  input  logic [lg_fetch_lp-1:0]                 resp_cnt_i,
  input  logic                                   resp_fault_i,
  input  logic                                   flush_i,
  output logic                                   out_v_o,
  output logic [vaddr_width_p-1:0]               out_pc_o,
  output logic [instr_width_p-1:0]               out_instr_o,
  output logic                                   out_fault_o,
  input  logic                                   out_ready_i,
  output logic [lg_depth_lp-1:0]                 occupancy_o,
  output logic [lg_depth_lp-1:0]                 outstanding_o
);

  localparam int ptr_w_lp = (depth_p > 1) ? $clog2(depth_p) : 1;
  // Wide enough to hold occupancy + outstanding + drop_cnt without overflow.
  localparam int sum_w_lp = lg_depth_lp + 2;
  localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(depth_p - 1);

  // Entry storage (data only, no reset: validity is tracked by occupancy).
  logic [vaddr_width_p-1:0]               pc_mem    [depth_p];
  logic [fetch_width_p*instr_width_p-1:0] instr_mem [depth_p];
  logic [lg_fetch_lp-1:0]                 cnt_mem   [depth_p];
  logic                                   fault_mem [depth_p];

  // Control state.
  logic [ptr_w_lp-1:0]    head, head_n;
  logic [ptr_w_lp-1:0]    tail, tail_n;
  logic [lg_depth_lp-1:0] occupancy, occupancy_n;
  logic [lg_depth_lp-1:0] outstanding, outstanding_n;
  logic [lg_depth_lp-1:0] drop_cnt, drop_cnt_n;
  logic [lg_fetch_lp-1:0] slot, slot_n;

  // Event decode.
  logic [sum_w_lp-1:0]    credit_sum;
  logic                   credit_ok;
  logic                   issue;
  logic                   has_entry;
  logic                   pop;
  logic                   retire;
  logic                   dropping;
  logic                   resp_accept;
  logic [lg_fetch_lp-1:0] last_slot;
  logic [vaddr_width_p-1:0] slot_offset;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == last_ptr_lp) ? '0 : p + 1'b1;
  endfunction

  assign credit_sum = sum_w_lp'(occupancy) + sum_w_lp'(outstanding) + sum_w_lp'(drop_cnt);
  assign credit_ok  = credit_sum < sum_w_lp'(depth_p);

  // Gated by reset_n_i so no credit is advertised while reset is held.
  assign req_ready_o = reset_n_i & ~flush_i & credit_ok;
  assign issue       = req_v_i & req_ready_o;

  assign has_entry = (occupancy != '0);
  assign out_v_o   = has_entry & ~flush_i;
  assign pop       = out_v_o & out_ready_i;

  // Fault entries are stored with cnt=1, so they retire on their first pop.
  assign last_slot = cnt_mem[head] - 1'b1;
  assign retire    = pop & (slot == last_slot);

  // While drops are pending, every response belongs to a pre-flush request.
  assign dropping    = (drop_cnt != '0);
  assign resp_accept = resp_v_i & ~flush_i & ~dropping;

  // Slot k sits at pc + 4*k; the add wraps modulo 2^vaddr_width_p.
  assign slot_offset = vaddr_width_p'({slot, 2'b00});

  assign out_pc_o    = has_entry ? (pc_mem[head] + slot_offset) : '0;
  assign out_fault_o = has_entry & fault_mem[head];
  assign out_instr_o = (has_entry & ~fault_mem[head])
                       ? instr_mem[head][slot*instr_width_p +: instr_width_p]
                       : '0;

  assign occupancy_o   = occupancy;
  assign outstanding_o = outstanding;

  always_comb begin
    head_n        = head;
    tail_n        = tail;
    occupancy_n   = occupancy;
    outstanding_n = outstanding;
    drop_cnt_n    = drop_cnt;
    slot_n        = slot;

    if (flush_i) begin
      // Every in-flight request becomes a drop. A response arriving in the
      // flush cycle is one of those requests, so it consumes one drop now.
      head_n        = tail;
      occupancy_n   = '0;
      slot_n        = '0;
      outstanding_n = '0;
      drop_cnt_n    = drop_cnt + outstanding - lg_depth_lp'(resp_v_i);
    end else begin
      outstanding_n = outstanding + lg_depth_lp'(issue) - lg_depth_lp'(resp_accept);
      occupancy_n   = occupancy + lg_depth_lp'(resp_accept) - lg_depth_lp'(retire);
      if (resp_v_i && dropping) begin
        drop_cnt_n = drop_cnt - 1'b1;
      end
      if (resp_accept) begin
        tail_n = ptr_inc(tail);
      end
      if (retire) begin
        head_n = ptr_inc(head);
        slot_n = '0;
      end else if (pop) begin
        slot_n = slot + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head        <= '0;
      tail        <= '0;
      occupancy   <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      slot        <= '0;
    end else begin
      head        <= head_n;
      tail        <= tail_n;
      occupancy   <= occupancy_n;
      outstanding <= outstanding_n;
      drop_cnt    <= drop_cnt_n;
      slot        <= slot_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (resp_accept) begin
      pc_mem[tail]    <= resp_pc_i;
      instr_mem[tail] <= resp_instr_i;
      cnt_mem[tail]   <= resp_fault_i ? lg_fetch_lp'(1) : resp_cnt_i;
      fault_mem[tail] <= resp_fault_i;
    end
  end

`ifndef SYNTHESIS
  // A non-fault response must carry 1..fetch_width_p slots.
  a_resp_cnt_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (resp_v_i && !resp_fault_i) |->
      (resp_cnt_i != '0 && resp_cnt_i <= lg_fetch_lp'(fetch_width_p)));

  // Every response must match an issued request (live or pending drop).
  a_resp_expected: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    resp_v_i |-> (outstanding != '0 || drop_cnt != '0));

  // The credit pool is never oversubscribed.
  a_credit_bound: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    credit_sum <= sum_w_lp'(depth_p));
`endif

endmodule
